// File: rtl/design_46.sv
// Pipelined two-operand ALU lane with valid/ready handshake,
// uniform stall of all stages and a saturating completion counter.
module design_46 #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y,
    output logic             flag,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] done_cnt
);

    logic [DEPTH-1:0] r_vld;
    logic [W-1:0]     r_y [DEPTH];
    logic             r_f [DEPTH];
    logic [CNT_W-1:0] r_cnt;

    logic [W:0]   w_sum;
    logic [W:0]   w_dif;
    logic [W-1:0] w_y;
    logic         w_f;
    logic         w_stall;
    logic         w_done;

    assign w_sum = {1'b0, a} + {1'b0, b};
    assign w_dif = {1'b0, a} - {1'b0, b};

    always_comb begin
        w_y = '0;
        w_f = 1'b0;
        unique case (op)
            3'b000: begin
                w_y = w_sum[W-1:0];
                w_f = w_sum[W];
            end
            3'b001: begin
                w_y = w_dif[W-1:0];
                w_f = w_dif[W];
            end
            3'b010: w_y = a & b;
            3'b011: w_y = a | b;
            3'b100: w_y = a ^ b;
            3'b101: begin
                w_y = w_sum[W] ? '1 : w_sum[W-1:0];
                w_f = w_sum[W];
            end
            3'b110: w_y = (a > b) ? a : b;
            3'b111: w_y = (a < b) ? a : b;
        endcase
    end

    // Whole pipe freezes, bubbles included, while the output waits.
    assign w_stall   = r_vld[DEPTH-1] && !out_ready;
    assign in_ready  = !rst && !w_stall;
    assign w_done    = r_vld[DEPTH-1] && out_ready;
    assign out_valid = r_vld[DEPTH-1];
    assign y         = r_y[DEPTH-1];
    assign flag      = r_f[DEPTH-1];
    assign done_cnt  = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_y[i] <= '0;
                r_f[i] <= 1'b0;
            end
        end else if (!w_stall) begin
            r_vld[0] <= in_valid;
            r_y[0]   <= w_y;
            r_f[0]   <= w_f;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_y[i]   <= r_y[i-1];
                r_f[i]   <= r_f[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt <= '0;
        end else if (w_done && r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_design_46.sv
// Scoreboard bench for design_46: driver queues expected results,
// an independent monitor pops and compares on each output handshake.
module tb_design_46;

    localparam int W     = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = '0;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     y;
    logic             flag;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] done_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;
    int acc0  = 0;
    int seen  = 0;
    logic [W:0] exp_q [$];
    int         del_log [$];
    logic [W:0] mon_e;
    logic       mon_hit;

    design_46 #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .flag(flag),
        .cnt_clr(cnt_clr), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timeout waiting, got none want event", nm);
    endtask

    // exp = {flag, y}
    task automatic send(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] z, input logic [W:0] e);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = z;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                last_acc = cyc;
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) tmo("send_accept");
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) tmo("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_hit = !rst && out_valid === 1'b1 && out_ready;
            if (mon_hit) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got y=%0h want none", y);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", {23'd0, flag, y}, {23'd0, mon_e});
                    del_log.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with in_valid held high
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_cnt", done_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // opcode sweep a=F0 b=20
        del_log.delete();
        send(3'b000, 8'hF0, 8'h20, 9'h110);
        acc0 = last_acc;
        send(3'b001, 8'hF0, 8'h20, 9'h0D0);
        send(3'b010, 8'hF0, 8'h20, 9'h020);
        send(3'b011, 8'hF0, 8'h20, 9'h0F0);
        send(3'b100, 8'hF0, 8'h20, 9'h0D0);
        send(3'b101, 8'hF0, 8'h20, 9'h1FF);
        send(3'b110, 8'hF0, 8'h20, 9'h0F0);
        send(3'b111, 8'hF0, 8'h20, 9'h020);
        idle(1);
        drain();
        chk("sweep_cnt", done_cnt, 8);
        chk("sweep_n", del_log.size(), 8);
        if (del_log.size() == 8) begin
            chk("sweep_latency", del_log[0] - acc0, DEPTH);
            chk("sweep_tput", del_log[7] - del_log[0], 7);
        end

        // boundaries
        send(3'b000, 8'hFF, 8'h01, 9'h100);
        send(3'b001, 8'h00, 8'h01, 9'h1FF);
        send(3'b101, 8'h7F, 8'h80, 9'h0FF);
        idle(1);
        drain();
        chk("bound_cnt", done_cnt, 11);

        // backpressure with a bubble after the third transaction
        del_log.delete();
        fork
            begin
                send(3'b000, 8'd0, 8'd1, 9'h001);
                send(3'b000, 8'd1, 8'd1, 9'h002);
                send(3'b000, 8'd2, 8'd1, 9'h003);
                idle(1);
                send(3'b000, 8'd3, 8'd1, 9'h004);
                send(3'b000, 8'd4, 8'd1, 9'h005);
                idle(1);
            end
            begin
                logic got;
                got = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) begin
                        got = 1'b1;
                        break;
                    end
                end
                if (!got) tmo("bp_first_valid");
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_y_hold", y, 8'h01);
                    chk("bp_valid_hold", out_valid, 1);
                    chk("bp_in_ready", in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_n", del_log.size(), 5);
        if (del_log.size() == 5) begin
            chk("bp_gap01", del_log[1] - del_log[0], 1);
            chk("bp_gap12", del_log[2] - del_log[1], 1);
            chk("bp_bubble", del_log[3] - del_log[2], 2);
            chk("bp_gap34", del_log[4] - del_log[3], 1);
        end
        chk("bp_cnt", done_cnt, 15);

        // counter saturation and clear priority
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_cnt", done_cnt, 0);
        for (int i = 0; i < 17; i++)
            send(3'b000, 8'(i), 8'd0, {1'b0, 8'(i)});
        idle(1);
        drain();
        chk("sat_cnt", done_cnt, 15);
        send(3'b000, 8'd3, 8'd4, 9'h007);
        in_valid = 1'b0;
        begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (out_valid) begin
                    got = 1'b1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            if (!got) tmo("clr_wait_valid");
        end
        cnt_clr = 1'b1;
        @(negedge clk);
        chk("clr_with_done", out_valid && out_ready, 1);
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_prio_cnt", done_cnt, 0);
        send(3'b000, 8'd1, 8'd1, 9'h002);
        idle(1);
        drain();
        chk("one_cnt", done_cnt, 1);

        // reset while two transactions are in flight
        out_ready = 1'b0;
        send(3'b000, 8'd10, 8'd1, 9'h00B);
        send(3'b000, 8'd20, 8'd1, 9'h015);
        in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mid_cnt", done_cnt, 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_no_out", seen, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_cnt_after", done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
